// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 0 is the rightmost element, so the list runs F down to 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to active-low segment lookup.
module hex_seg_lut
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-aligned
// value updates, inter-slot blanking and leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;

  logic [PW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic [VW-1:0]     pending_q, pending_d;
  logic              pend_q, pend_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              fd_q, fd_d;

  logic              wrap;
  logic              bnd;
  logic [3:0]        nib;
  logic [6:0]        lut_seg;
  logic [DIGITS-1:0] sup;
  logic              all_zero;

  assign wrap = (presc_q == PW'(SCAN_DIV - 1));
  assign bnd  = wrap && (slot_q == SW'(DIGITS - 1));
  assign nib  = shadow_q[{slot_q, 2'b00} +: 4];

  hex_seg_lut u_lut (
    .nib (nib),
    .seg (lut_seg)
  );

  always_comb begin
    presc_d = wrap ? '0 : presc_q + PW'(1);
    slot_d  = slot_q;
    if (wrap) begin
      if (slot_q == SW'(DIGITS - 1)) slot_d = '0;
      else                           slot_d = slot_q + SW'(1);
    end
  end

  // A load on the boundary cycle itself bypasses pending.
  always_comb begin
    pending_d = pending_q;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    if (load) begin
      pending_d = value;
      pend_d    = 1'b1;
    end
    if (bnd) begin
      if (load)        shadow_d = value;
      else if (pend_q) shadow_d = pending_q;
      pend_d = 1'b0;
    end
  end

  always_comb begin
    all_zero = 1'b1;
    sup      = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (shadow_q[4*k +: 4] == 4'h0);
      sup[k]   = all_zero;
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    fd_d  = bnd;
    if (presc_q >= PW'(BLANK_CYC)) begin
      dp_d = ~dp_mask[slot_q];
      if (!(lz_en && sup[slot_q])) begin
        an_d  = ~(DIGITS'(1) << slot_q);
        seg_d = lut_seg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      slot_q    <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      slot_q    <= slot_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected digit displays are
// queued per frame and compared as each anode lights.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg_scan_ctrl #(
    .DIGITS    (4),
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .dp_mask    (dp_mask),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       gap;
  } exp_t;

  exp_t       q[$];
  logic [6:0] tbl [16];
  int         checks;
  int         passes;
  int         cyc;
  int         last_fd;
  bit         armed;
  bit         prev_d3_vis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input bit lz,
                            input logic [3:0] dpm);
    exp_t e;
    bit   vis;
    for (int k = 0; k < 4; k++) begin
      vis = !(lz && k >= 1 && ((v >> (4 * k)) == 16'h0));
      if (vis) begin
        e.an  = ~(4'b0001 << k);
        e.seg = tbl[v[4*k +: 4]];
        e.dp  = ~dpm[k];
        e.gap = (k == 0) ? prev_d3_vis : 1'b1;
        q.push_back(e);
      end
      if (k == 3) prev_d3_vis = vis;
    end
  endtask

  task automatic pulse(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_frame(input bit chk_period);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    check("fd_seen", 32'(frame_done), 1);
    check("q_empty", q.size(), 0);
    if (chk_period) check("fd_period", cyc - last_fd, 32);
    last_fd = cyc;
  endtask

  // Lit-start / lit-end monitor
  initial begin
    logic [3:0] prev_an;
    int         lit_len;
    int         blank_len;
    bit         lit_cmp;
    exp_t       e;
    prev_an   = 4'hF;
    lit_len   = 0;
    blank_len = 0;
    lit_cmp   = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (armed) begin
          check("one_anode", 32'($countones(~an) <= 1), 1);
          if (an != 4'hF && prev_an != 4'hF)
            check("an_switch", an, prev_an);
        end
        if (an != 4'hF && prev_an == 4'hF) begin
          lit_cmp = 0;
          if (armed) begin
            if (q.size() == 0) begin
              check("unexpected_lit", an, 4'hF);
            end else begin
              e = q.pop_front();
              check("an", an, e.an);
              check("seg", seg, e.seg);
              check("dp", dp, e.dp);
              if (e.gap) check("gap", blank_len, 2);
              lit_cmp = 1;
            end
          end
          lit_len = 1;
        end else if (an != 4'hF) begin
          lit_len++;
        end else begin
          if (prev_an != 4'hF) begin
            if (lit_cmp) check("lit_len", lit_len, 6);
            lit_cmp   = 0;
            blank_len = 0;
          end
          blank_len++;
        end
        prev_an = an;
      end
    end
  end

  initial begin
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    checks      = 0;
    passes      = 0;
    last_fd     = 0;
    armed       = 0;
    prev_d3_vis = 1;
    reset   = 1'b1;
    load    = 1'b0;
    value   = 16'h0;
    dp_mask = 4'h0;
    lz_en   = 1'b0;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("lit_before_rst", an, 4'hE);

    // Asynchronous reset mid-slot
    #2 reset = 1'b1;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dp, 1);
    check("arst_fd", frame_done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("post_rst_dark", an, 4'hF);
    @(posedge clk);
    #1 check("post_rst_an", an, 4'hE);
    check("post_rst_seg", seg, 7'h40);
    check("post_rst_dp", dp, 1);

    // First value, shown from the next frame
    @(negedge clk);
    pulse(16'h1234);
    wait_frame(0);
    armed = 1;
    push_frame(16'h1234, 0, 4'h0);

    // Two loads in one frame: last wins, no tearing
    repeat (3) @(negedge clk);
    pulse(16'hABCD);
    repeat (4) @(negedge clk);
    pulse(16'h00EF);
    wait_frame(1);
    push_frame(16'h00EF, 0, 4'h0);

    // Load exactly on the boundary cycle overrides pending
    pulse(16'h9999);
    repeat (30) @(negedge clk);
    check("pend_set", 32'(dut.pend_q), 1);
    pulse(16'h5555);
    check("fd_at_bnd", 32'(frame_done), 1);
    check("q_empty_bnd", q.size(), 0);
    check("pend_clr", 32'(dut.pend_q), 0);
    check("fd_period_bnd", cyc - last_fd, 32);
    last_fd = cyc;
    push_frame(16'h5555, 0, 4'h0);
    wait_frame(1);
    push_frame(16'h5555, 0, 4'h0);

    // Leading-zero blanking
    lz_en = 1'b1;
    pulse(16'h0070);
    wait_frame(1);
    push_frame(16'h0070, 1, 4'h0);
    pulse(16'h0000);
    wait_frame(1);
    push_frame(16'h0000, 1, 4'h0);

    // Decimal point on digit 2, no blanking
    wait_frame(1);
    lz_en   = 1'b0;
    dp_mask = 4'b0100;
    push_frame(16'h0000, 0, 4'b0100);
    @(negedge clk);
    check("fd_width", frame_done, 0);
    pulse(16'h1234);
    wait_frame(1);
    push_frame(16'h1234, 0, 4'b0100);
    wait_frame(1);
    armed = 0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
